// File: rtl/sram_read_streamer_if.sv
// Command, SRAM read-port and output-stream signals of the SRAM read streamer.
// master = streamer side, slave = environment (command source, SRAM, stream sink).
interface sram_read_streamer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  re;
  logic [ADDR_WIDTH-1:0] radr;
  logic [DATA_WIDTH-1:0] q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, q, out_ready,
    output cmd_ready, re, radr, out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, q, out_ready,
    input  cmd_ready, re, radr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/sram_read_streamer.sv
// Burst reader for the banked 1R1W SRAM wrapper: issues sequential reads, captures q
// one cycle later and streams words out through a 2-entry buffer with out_last.
module sram_read_streamer #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 12,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH       = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_read_streamer_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, BANK_GAP, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] radr_q, radr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;

  logic                  out_valid;
  logic                  pop;
  logic                  push;
  logic                  tail;
  logic [2:0]            load;
  logic                  can_issue;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_word;
  logic                  bank_change;

  assign out_valid   = (occ_q != 2'd0);
  assign pop         = out_valid & bus.out_ready;
  assign push        = inflight_q;
  assign tail        = head_q ^ occ_q[0];
  assign load        = {1'b0, occ_q} + {2'b00, inflight_q};
  // A word leaving this cycle frees a slot for the read issued now.
  assign can_issue   = pop ? (load < 3'd3) : (load < 3'd2);
  assign next_addr   = radr_q + ADDR_WIDTH'(1);
  assign last_word   = (remaining_q == LEN_WIDTH'(1));
  assign bank_change = next_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH] !=
                       radr_q[ADDR_WIDTH-1:BANK_ADDR_WIDTH];

  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    head_d     = head_q;
    occ_d      = occ_q;
    if (push) begin
      buf_data_d[tail] = bus.q;
      buf_last_d[tail] = inflight_last_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    radr_d          = radr_q;
    remaining_d     = remaining_q;
    issue           = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && (bus.cmd_len != '0)) begin
          state_d     = READ;
          radr_d      = bus.cmd_base;
          remaining_d = bus.cmd_len;
        end
      end
      READ: begin
        if (can_issue) begin
          issue       = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          // radr must keep its bank for one more cycle so the wrapper's q mux
          // still selects the bank of the word being returned.
          if (last_word) begin
            state_d = DRAIN;
          end else if (bank_change) begin
            state_d = BANK_GAP;
          end else begin
            radr_d = next_addr;
          end
        end
      end
      BANK_GAP: begin
        radr_d  = next_addr;
        state_d = READ;
      end
      DRAIN: begin
        if (!inflight_q && (occ_d == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue & last_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      radr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_q          <= 1'b0;
      occ_q           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      radr_q          <= radr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_q          <= head_d;
      occ_q           <= occ_d;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_last_q[i] <= buf_last_d[i];
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) & ~rst;
  assign bus.re        = issue & ~rst;
  assign bus.radr      = radr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_data_q[head_q];
  assign bus.out_last  = buf_last_q[head_q] & out_valid;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_read_streamer.sv
// Scoreboard bench for sram_read_streamer with a banked SRAM model whose q mux
// follows the current radr, so a premature bank switch corrupts data.
module tb_sram_read_streamer;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int LW = 13;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  sram_read_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(10), .LEN_WIDTH(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [4096];
  logic [DW-1:0] bank_q [4];

  always @(posedge clk) begin
    if (bus.re) bank_q[bus.radr[11:10]] <= mem[bus.radr];
  end
  assign bus.q = bank_q[bus.radr[11:10]];

  exp_t        exp_q[$];
  logic [12:0] log_q[$];
  logic [12:0] ref_log[$];
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  int          popped = 0;
  bit          bp = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, issue-window check, per-cycle read log.
  initial begin
    exp_t e;
    int   outstanding;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.busy) log_q.push_back({bus.re, bus.radr});
        if (bus.re) begin
          outstanding = issued - popped - ((bus.out_valid && bus.out_ready) ? 1 : 0);
          chk("issue_window", DW'(outstanding < 2), DW'(1));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", DW'(bus.out_last), DW'(e.last));
          end
          popped++;
        end
        if (bus.re) issued++;
      end
    end
  end

  // Stream sink ready: constant 1, or the 1,0,0 pattern under backpressure.
  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        bus.out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        bus.out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic send(input logic [AW-1:0] base, input logic [LW-1:0] len);
    exp_t e;
    for (int i = 0; i < int'(len); i++) begin
      e.data = DW'((int'(base) + i) % 4096);
      e.last = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    log_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.out_valid) && n < 300);
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%0b expected 0", name, bus.busy);
    end
    chk({name, "_leftover"}, DW'(exp_q.size()), DW'(0));
  endtask

  task automatic check_log(input string name);
    while (log_q.size() > 0 && log_q[0][12] == 1'b0) void'(log_q.pop_front());
    while (log_q.size() > 0 && log_q[log_q.size()-1][12] == 1'b0) void'(log_q.pop_back());
    chk({name, "_log_len"}, DW'(log_q.size()), DW'(ref_log.size()));
    for (int i = 0; i < ref_log.size() && i < log_q.size(); i++) begin
      chk({name, "_re_radr"}, DW'(log_q[i]), DW'(ref_log[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
    for (int i = 0; i < 4; i++) bank_q[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", DW'(bus.cmd_ready), DW'(0));
    chk("rst_re", DW'(bus.re), DW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", DW'(bus.cmd_ready), DW'(1));
    chk("idle_re", DW'(bus.re), DW'(0));
    chk("idle_radr", DW'(bus.radr), DW'(0));
    chk("idle_out_valid", DW'(bus.out_valid), DW'(0));
    chk("idle_out_data", bus.out_data, DW'(0));
    chk("idle_out_last", DW'(bus.out_last), DW'(0));
    chk("idle_busy", DW'(bus.busy), DW'(0));

    // Basic burst
    send(12'd5, 13'd4);
    wait_idle("basic");
    ref_log = '{13'h1005, 13'h1006, 13'h1007, 13'h1008};
    check_log("basic");
    chk("basic_cmd_ready", DW'(bus.cmd_ready), DW'(1));

    // Bank crossing
    send(12'd1022, 13'd4);
    wait_idle("bank");
    ref_log = '{13'h13FE, 13'h13FF, 13'h03FF, 13'h1400, 13'h1401};
    check_log("bank");

    // Address wrap 4095 -> 0
    send(12'd4094, 13'd3);
    wait_idle("wrap");
    ref_log = '{13'h1FFE, 13'h1FFF, 13'h0FFF, 13'h1000};
    check_log("wrap");

    // Backpressure
    bp = 1'b1;
    send(12'd40, 13'd8);
    wait_idle("bp");
    bp = 1'b0;

    // Zero length
    send(12'd7, 13'd0);
    repeat (4) begin
      @(negedge clk);
      chk("zero_re", DW'(bus.re), DW'(0));
      chk("zero_out_valid", DW'(bus.out_valid), DW'(0));
      chk("zero_cmd_ready", DW'(bus.cmd_ready), DW'(1));
    end

    // Reset in the middle of a long burst
    send(12'd200, 13'd16);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    issued = 0;
    popped = 0;
    @(negedge clk);
    chk("abort_re", DW'(bus.re), DW'(0));
    chk("abort_out_valid", DW'(bus.out_valid), DW'(0));
    chk("abort_busy", DW'(bus.busy), DW'(0));
    send(12'd100, 13'd2);
    wait_idle("after_abort");
    ref_log = '{13'h1064, 13'h1065};
    check_log("after_abort");
    repeat (5) @(negedge clk);
    chk("final_out_valid", DW'(bus.out_valid), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
- Sits directly downstream of the 1R1W SRAM wrapper (ccs_ram_sync_1R1W, 128b x 4096, four 1024-word banks) and drives its read port.
- Accepts a burst command (base address, word count), issues sequential reads, and captures q one cycle after each read.
- Delivers the words on a valid/ready stream with `out_last`, through a 2-entry output buffer that absorbs backpressure.
- Serves as the activation/weight fetch front end for the ConvHLS datapath.

Parameters:
- DATA_WIDTH, 128, word width; equals wrapper data_width.
- ADDR_WIDTH, 12, word address width; equals wrapper addr_width.
- BANK_ADDR_WIDTH, 10, in-bank address bits; radr[ADDR_WIDTH-1:BANK_ADDR_WIDTH] is the bank select.
- LEN_WIDTH, 13, burst length width; covers 0..4096 words.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  number of words.
- re  out  1  read enable to wrapper.
- radr  out  ADDR_WIDTH  read address to wrapper; registered.
- q  in  DATA_WIDTH  wrapper read data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  marks the final word of a burst.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: cmd_ready=0 during rst, 1 after; re=0; radr=0; out_valid=0; out_data=0; out_last=0; busy=0. State=IDLE, buffer empty, in-flight flag cleared.
- SRAM timing contract:
  - re/radr sampled at edge t; q valid and captured at edge t+1, so read latency is 1 cycle.
  - The wrapper's bank mux on q uses the current radr. radr at edge t+1 must therefore have the same bank bits as the read issued at t.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch base and len.
    - len=0: stay IDLE; emit nothing.
    - Otherwise: go to READ; radr=base takes effect next cycle.
  - READ: issue condition is (occupancy + inflight - pop) < 2, where pop = out_valid & out_ready.
    - On issue: re=1, remaining decremented, inflight set.
    - Next address is radr+1, modulo 2^ADDR_WIDTH; 4095 wraps to 0.
    - Normal case: radr advances the next cycle.
    - Bank change (next address's bank bits differ, including the 4095->0 wrap): go to BANK_GAP; radr holds.
    - Last word issued: go to DRAIN; radr holds.
  - BANK_GAP: exactly one cycle. re=0, radr held; in-flight word captured. Next: radr=next address; return to READ.
  - DRAIN: re=0. Wait until inflight=0 and the buffer is empty, then go to IDLE.
- Stall on issue condition: re=0 and radr held. No other state change.
- Capture: when inflight is set at an edge, q is written to the buffer tail and tagged last if it was the final word. The issue rule guarantees the buffer never overflows.
- Output: out_* present the buffer head, registered. A pop and a capture in the same cycle are both honoured.
- Throughput: 1 word/cycle with out_ready held high, plus 1 bubble per bank crossing.
- Reset mid-burst: abort. Buffer flushed, in-flight word discarded, outputs return to reset values. No word of the aborted burst appears after reset.
- New commands are accepted only in IDLE; cmd_ready=0 while busy.

Test Plan:
- Basic burst: preload mem[i]=i. base=5, len=4, out_ready=1.
  - re high 4 consecutive cycles; radr=5,6,7,8.
  - Outputs 5,6,7,8; out_last only on 8; busy falls after the last pop.
- Bank crossing: base=1022, len=4.
  - radr=1022,1023, then one re=0 cycle with radr=1023, then 1024,1025.
  - Data 1022..1025 correct (no bank-mux corruption).
- Wrap: base=4094, len=3.
  - Outputs mem[4094], mem[4095], mem[0].
  - A gap cycle precedes radr=0.
- Backpressure: len=8, out_ready toggling 1,0,0,1,...
  - No loss or duplication; re never asserts when occupancy+inflight would exceed 2.
  - Order preserved.
- Zero length and reset: cmd_len=0 -> no re, no out_valid, cmd_ready stays 1.
  - rst for one cycle in the middle of a len=16 burst -> re=0 and out_valid=0 next cycle.
  - A following burst base=100, len=2 returns only mem[100], mem[101].
